// File: rtl/rom_loader_pkg.sv
// Loader constants, state encoding and address helper shared by the ROM loader.
// Bus widths mirror the core's instruction ROM port.
package rom_loader_pkg;

    localparam int unsigned INST_ADDR_W = 32;
    localparam int unsigned INST_DATA_W = 32;

    localparam logic [7:0] LOADER_SYNC = 8'hA5;
    localparam logic [7:0] LOADER_ACK  = 8'h06;
    localparam logic [7:0] LOADER_NAK  = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_RESP   = 3'd5
    } loader_state_t;

    // Byte address of word `idx` relative to the load base.
    function automatic logic [INST_ADDR_W-1:0] loader_word_addr(
        input logic [INST_ADDR_W-1:0] base,
        input logic [15:0]            idx
    );
        return base + {14'b0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/rom_loader.sv
// Serial program loader: parses a SYNC/length/data/checksum frame from the UART,
// writes assembled words into the instruction ROM and answers with ACK or NAK.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter logic [INST_ADDR_W-1:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned            MAX_WORDS      = 4096,
    parameter int unsigned            TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             rx_data_i,
    input  logic                   rx_valid_i,
    output logic [7:0]             tx_data_o,
    output logic                   tx_valid_o,
    input  logic                   tx_ready_i,
    output logic                   wr_en_o,
    output logic [INST_ADDR_W-1:0] wr_addr_o,
    output logic [INST_DATA_W-1:0] wr_data_o,
    output logic                   hold_o,
    output logic                   done_o,
    output logic                   err_o
);

    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] MAX_N    = 32'(MAX_WORDS);

    loader_state_t state;
    logic [7:0]    len_lo;
    logic [15:0]   n_words;
    logic [15:0]   word_idx;
    logic [1:0]    byte_idx;
    logic [23:0]   word_buf;
    logic [7:0]    csum;
    logic [31:0]   tmo_cnt;
    logic [15:0]   len_rx;

    assign len_rx = {rx_data_i, len_lo};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            tx_data_o  <= '0;
            tx_valid_o <= 1'b0;
            wr_en_o    <= 1'b0;
            wr_addr_o  <= '0;
            wr_data_o  <= '0;
            hold_o     <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            len_lo     <= '0;
            n_words    <= '0;
            word_idx   <= '0;
            byte_idx   <= '0;
            word_buf   <= '0;
            csum       <= '0;
            tmo_cnt    <= '0;
        end else begin
            wr_en_o <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (rx_valid_i && rx_data_i == LOADER_SYNC) begin
                        state    <= ST_LEN_LO;
                        hold_o   <= 1'b1;
                        done_o   <= 1'b0;
                        err_o    <= 1'b0;
                        byte_idx <= '0;
                        word_idx <= '0;
                        csum     <= '0;
                        tmo_cnt  <= '0;
                    end
                end
                ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CSUM: begin
                    // A byte arriving on the terminal count wins over the timeout.
                    if (rx_valid_i) begin
                        tmo_cnt <= '0;
                        if (state == ST_LEN_LO) begin
                            len_lo <= rx_data_i;
                            state  <= ST_LEN_HI;
                        end else if (state == ST_LEN_HI) begin
                            n_words <= len_rx;
                            if (len_rx == 16'd0 || {16'b0, len_rx} > MAX_N) begin
                                state      <= ST_RESP;
                                tx_valid_o <= 1'b1;
                                tx_data_o  <= LOADER_NAK;
                            end else begin
                                state <= ST_DATA;
                            end
                        end else if (state == ST_DATA) begin
                            csum     <= csum + rx_data_i;
                            byte_idx <= byte_idx + 2'd1;
                            case (byte_idx)
                                2'd0: word_buf[7:0]   <= rx_data_i;
                                2'd1: word_buf[15:8]  <= rx_data_i;
                                2'd2: word_buf[23:16] <= rx_data_i;
                                default: begin
                                    wr_en_o   <= 1'b1;
                                    wr_addr_o <= loader_word_addr(BASE_ADDR, word_idx);
                                    wr_data_o <= {rx_data_i, word_buf};
                                    word_idx  <= word_idx + 16'd1;
                                    if (word_idx == n_words - 16'd1) begin
                                        state <= ST_CSUM;
                                    end
                                end
                            endcase
                        end else begin
                            state      <= ST_RESP;
                            tx_valid_o <= 1'b1;
                            tx_data_o  <= (rx_data_i == csum) ? LOADER_ACK : LOADER_NAK;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        state      <= ST_RESP;
                        tx_valid_o <= 1'b1;
                        tx_data_o  <= LOADER_NAK;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end
                ST_RESP: begin
                    if (tx_ready_i) begin
                        state      <= ST_IDLE;
                        tx_valid_o <= 1'b0;
                        hold_o     <= 1'b0;
                        done_o     <= (tx_data_o == LOADER_ACK);
                        err_o      <= (tx_data_o != LOADER_ACK);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: directed frames plus randomized frames
// compared against a frame-level reference model.
module tb_rom_loader;

    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam int unsigned MAXW = 4096;
    localparam int unsigned TMO  = 16;
    localparam logic [7:0]  ACK  = 8'h06;
    localparam logic [7:0]  NAK  = 8'h15;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        hold;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    rom_loader #(
        .BASE_ADDR(BASE),
        .MAX_WORDS(MAXW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_data_i(rx_data),
        .rx_valid_i(rx_valid),
        .tx_data_o(tx_data),
        .tx_valid_o(tx_valid),
        .tx_ready_i(tx_ready),
        .wr_en_o(wr_en),
        .wr_addr_o(wr_addr),
        .wr_data_o(wr_data),
        .hold_o(hold),
        .done_o(done),
        .err_o(err)
    );

    int total = 0;
    int bad   = 0;

    logic [63:0] wr_log[$];
    logic [7:0]  frame_q[$];

    always @(negedge clk) begin
        if (wr_en) wr_log.push_back({wr_addr, wr_data});
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic build_frame(input int unsigned n, input bit corrupt);
        logic [7:0] s;
        logic [7:0] b;
        s = 8'h00;
        frame_q = {8'hA5, n[7:0], n[15:8]};
        for (int unsigned i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            frame_q.push_back(b);
            s = s + b;
        end
        if (corrupt) s = s + 8'($urandom_range(255, 1));
        frame_q.push_back(s);
    endtask

    // Sends frame_q, predicts writes and the response from the frame rules,
    // then completes the tx handshake after ready_delay stalled cycles.
    task automatic do_frame(input string tag, input int unsigned max_gap, input int unsigned ready_delay);
        int unsigned n;
        bit          len_ok;
        logic [7:0]  sum;
        logic [7:0]  resp;
        logic [31:0] w;
        logic [63:0] exp_w[$];
        int unsigned nb;

        n      = {16'b0, frame_q[2], frame_q[1]};
        len_ok = (n != 0) && (n <= MAXW);
        sum    = 8'h00;
        exp_w  = {};
        if (len_ok) begin
            for (int unsigned i = 0; i < n; i++) begin
                w = 32'h0;
                for (int unsigned j = 0; j < 4; j++) begin
                    w   = w | (32'(frame_q[3 + 4 * i + j]) << (8 * j));
                    sum = sum + frame_q[3 + 4 * i + j];
                end
                exp_w.push_back({BASE + 32'(4 * i), w});
            end
            resp = (frame_q[3 + 4 * n] == sum) ? ACK : NAK;
        end else begin
            resp = NAK;
        end

        wr_log.delete();
        nb = frame_q.size();
        for (int unsigned k = 0; k < nb; k++) begin
            if (k > 0) repeat ($urandom_range(max_gap, 0)) tick();
            send_byte(frame_q[k]);
            if (k == 0) begin
                check({tag, " hold_after_sync"}, 64'(hold), 64'd1);
                check({tag, " flags_cleared"}, {62'b0, done, err}, 64'd0);
            end
            if (len_ok && k >= 3 && k < 3 + 4 * n && (k - 3) % 4 == 3) begin
                check({tag, " wr_en_pulse"}, 64'(wr_en), 64'd1);
                check({tag, " wr_addr_data"}, {wr_addr, wr_data}, exp_w[(k - 3) / 4]);
            end
        end

        check({tag, " tx_valid_rise"}, 64'(tx_valid), 64'd1);
        check({tag, " tx_data"}, 64'(tx_data), 64'(resp));
        check({tag, " hold_in_resp"}, 64'(hold), 64'd1);

        for (int unsigned c = 0; c < ready_delay; c++) begin
            rx_data  = (c % 2 == 0) ? 8'hA5 : 8'($urandom);
            rx_valid = 1'b1;
            tick();
            check({tag, " stall_tx_valid"}, 64'(tx_valid), 64'd1);
            check({tag, " stall_tx_data"}, 64'(tx_data), 64'(resp));
        end
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;

        check({tag, " tx_valid_drop"}, 64'(tx_valid), 64'd0);
        check({tag, " hold_drop"}, 64'(hold), 64'd0);
        check({tag, " done"}, 64'(done), 64'(resp == ACK));
        check({tag, " err"}, 64'(err), 64'(resp == NAK));
        check({tag, " write_count"}, 64'(wr_log.size()), 64'(exp_w.size()));
        for (int unsigned i = 0; i < exp_w.size() && i < wr_log.size(); i++) begin
            check({tag, " write_log"}, wr_log[i], exp_w[i]);
        end
        tick();
    endtask

    initial begin
        int unsigned rn;
        bit          rc;

        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        repeat (3) tick();
        check("rst tx_data", 64'(tx_data), 64'd0);
        check("rst tx_valid", 64'(tx_valid), 64'd0);
        check("rst wr_en", 64'(wr_en), 64'd0);
        check("rst wr_addr", 64'(wr_addr), 64'd0);
        check("rst wr_data", 64'(wr_data), 64'd0);
        check("rst hold_done_err", {61'b0, hold, done, err}, 64'd0);
        rst = 1'b0;
        tick();

        // Non-sync bytes in idle are ignored.
        send_byte(8'h12);
        send_byte(8'h5A);
        check("idle ignore hold", 64'(hold), 64'd0);

        frame_q = {8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h14};
        do_frame("single", 0, 0);

        frame_q = {8'hA5, 8'h03, 8'h00,
                   8'h01, 8'h00, 8'h00, 8'h00,
                   8'h02, 8'h00, 8'h00, 8'h00,
                   8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        do_frame("multi", 0, 0);

        frame_q = {8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h15};
        do_frame("badcsum", 0, 0);

        frame_q = {8'hA5, 8'h00, 8'h00};
        do_frame("len0", 0, 0);
        frame_q = {8'hA5, 8'h01, 8'h10};
        do_frame("len4097", 0, 0);

        // Timeout: NAK appears exactly TMO cycles after the last byte.
        wr_log.delete();
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'hAA);
        repeat (TMO - 1) tick();
        check("tmo early", 64'(tx_valid), 64'd0);
        tick();
        check("tmo tx_valid", 64'(tx_valid), 64'd1);
        check("tmo tx_data", 64'(tx_data), 64'(NAK));
        check("tmo hold", 64'(hold), 64'd1);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        check("tmo hold_drop", 64'(hold), 64'd0);
        check("tmo err", {62'b0, done, err}, 64'd1);
        check("tmo writes", 64'(wr_log.size()), 64'd0);
        tick();

        frame_q = {8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h38};
        do_frame("backpressure", 0, 10);

        // Reset mid-DATA aborts the frame with no response.
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        rst = 1'b1;
        tick();
        check("midrst tx", {55'b0, tx_data, tx_valid}, 64'd0);
        check("midrst wr_en", 64'(wr_en), 64'd0);
        check("midrst wr_bus", {wr_addr, wr_data}, 64'd0);
        check("midrst flags", {61'b0, hold, done, err}, 64'd0);
        rst = 1'b0;
        tick();
        frame_q = {8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
        do_frame("after_rst", 0, 0);

        for (int unsigned f = 0; f < 20; f++) begin
            rn = $urandom_range(5, 1);
            rc = ($urandom_range(9, 0) < 3);
            build_frame(rn, rc);
            do_frame("random", 3, $urandom_range(4, 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
